// File: rtl/laser_pkg.sv
// Shared types and constants for the laser-placement front end.
// Point format, frame size and feeder state encoding.
package laser_pkg;

  localparam int N_OBJ   = 40;
  localparam int COORD_W = 4;
  localparam int PTR_W   = $clog2(N_OBJ);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PULSE     = 2'd1,
    STREAM    = 2'd2,
    WAIT_DONE = 2'd3
  } feed_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

endpackage

// File: rtl/laser_frame_feeder_if.sv
// Valid/ready point source feeding the frame feeder.
// master = point producer, slave = feeder.
interface laser_frame_feeder_if;
  import laser_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [COORD_W-1:0] in_x;
  logic [COORD_W-1:0] in_y;

  modport master (
    output in_valid, in_x, in_y,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_x, in_y,
    output in_ready
  );

endinterface

// File: rtl/laser_pingpong_buf.sv
// Two-bank point store: write side fills a bank, read side
// drains it and hands it back with a release strobe.
module laser_pingpong_buf
  import laser_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_en,
  input  point_t           wr_pt,
  output logic             wr_ready,
  input  logic [PTR_W-1:0] rd_ptr,
  output point_t           rd_pt,
  output logic             rd_full,
  input  logic             release_bank
);

  point_t           mem [0:1][0:N_OBJ-1];
  logic [1:0]       full;
  logic             wr_bank;
  logic             rd_bank;
  logic [PTR_W-1:0] wr_ptr;
  logic             wr_fire;

  assign wr_ready = !full[wr_bank] && !RST;
  assign wr_fire  = wr_en && wr_ready;
  assign rd_full  = full[rd_bank];
  assign rd_pt    = mem[rd_bank][rd_ptr];

  // Writer and reader never own the same bank at once
  always_ff @(posedge CLK) begin
    if (RST) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_ptr  <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_ptr == PTR_W'(N_OBJ-1)) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_ptr        <= '0;
        end else begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
      end
      if (release_bank) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_fire) mem[wr_bank][wr_ptr] <= wr_pt;
  end

endmodule

// File: rtl/laser_frame_feeder.sv
// Frame feeder for the 40-point laser core: buffer, replay, capture.
// Optional watchdog on core DONE: define LASER_FEED_TIMEOUT_EN.
module laser_frame_feeder
  import laser_pkg::*;
#(
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic               CLK,
  input  logic               RST,
  laser_frame_feeder_if.slave src,
  output logic               core_rst,
  output logic [COORD_W-1:0] core_x,
  output logic [COORD_W-1:0] core_y,
  input  logic               core_done,
  input  logic [COORD_W-1:0] core_c1x,
  input  logic [COORD_W-1:0] core_c1y,
  input  logic [COORD_W-1:0] core_c2x,
  input  logic [COORD_W-1:0] core_c2y,
  output logic               res_valid,
  output logic [COORD_W-1:0] res_c1x,
  output logic [COORD_W-1:0] res_c1y,
  output logic [COORD_W-1:0] res_c2x,
  output logic [COORD_W-1:0] res_c2y,
  output logic               res_err
);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be positive");
  end

  feed_state_t      state;
  feed_state_t      state_nx;
  logic [PTR_W-1:0] rd_ptr;
  point_t           rd_pt;
  point_t           wr_pt;
  point_t           hold_pt;
  logic             rd_full;
  logic             release_bank;
  logic             done_fire;
  logic             to_fire;

  assign wr_pt = '{x: src.in_x, y: src.in_y};

  laser_pingpong_buf u_buf (
    .CLK          (CLK),
    .RST          (RST),
    .wr_en        (src.in_valid),
    .wr_pt        (wr_pt),
    .wr_ready     (src.in_ready),
    .rd_ptr       (rd_ptr),
    .rd_pt        (rd_pt),
    .rd_full      (rd_full),
    .release_bank (release_bank)
  );

`ifdef LASER_FEED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wd_cnt;

  always_ff @(posedge CLK) begin
    if (RST || state != WAIT_DONE) wd_cnt <= '0;
    else if (wd_cnt != CNT_W'(TIMEOUT_CYC)) wd_cnt <= wd_cnt + CNT_W'(1);
  end

  assign to_fire = (state == WAIT_DONE) &&
                   (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign to_fire = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    release_bank = 1'b0;
    done_fire    = 1'b0;
    case (state)
      IDLE:   if (rd_full) state_nx = PULSE;
      PULSE:  state_nx = STREAM;
      STREAM: begin
        if (rd_ptr == PTR_W'(N_OBJ-1)) begin
          release_bank = 1'b1;
          state_nx     = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (core_done) begin
          done_fire = 1'b1;
          state_nx  = IDLE;
        end else if (to_fire) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr  <= '0;
      hold_pt <= '0;
    end else if (state == PULSE) begin
      rd_ptr <= '0;
    end else if (state == STREAM) begin
      rd_ptr  <= rd_ptr + PTR_W'(1);
      hold_pt <= rd_pt;
    end
  end

  // Points go straight from storage so point 0 follows the pulse
  assign core_rst = RST || (state == PULSE);
  assign core_x   = (state == STREAM) ? rd_pt.x : hold_pt.x;
  assign core_y   = (state == STREAM) ? rd_pt.y : hold_pt.y;

  always_ff @(posedge CLK) begin
    if (RST) begin
      res_valid <= 1'b0;
      res_err   <= 1'b0;
      res_c1x   <= '0;
      res_c1y   <= '0;
      res_c2x   <= '0;
      res_c2y   <= '0;
    end else begin
      res_valid <= done_fire || to_fire;
      res_err   <= to_fire && !done_fire;
      if (done_fire) begin
        res_c1x <= core_c1x;
        res_c1y <= core_c1y;
        res_c2x <= core_c2x;
        res_c2y <= core_c2y;
      end else if (to_fire) begin
        res_c1x <= '0;
        res_c1y <= '0;
        res_c2x <= '0;
        res_c2y <= '0;
      end
    end
  end

endmodule

// File: tb/tb_laser_frame_feeder.sv
// Scoreboard bench for laser_frame_feeder with a core model.
// Timeout checks run when LASER_FEED_TIMEOUT_EN is defined.
module tb_laser_frame_feeder;
  import laser_pkg::*;

`ifdef LASER_FEED_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 65535;
`endif

  typedef struct {
    int x;
    int y;
  } pt_s;

  typedef struct {
    int c1x;
    int c1y;
    int c2x;
    int c2y;
    int err;
    int cyc;
  } res_s;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic core_rst, core_done;
  logic [COORD_W-1:0] core_x, core_y;
  logic [COORD_W-1:0] core_c1x, core_c1y, core_c2x, core_c2y;
  logic res_valid, res_err;
  logic [COORD_W-1:0] res_c1x, res_c1y, res_c2x, res_c2y;

  laser_frame_feeder_if src();

  laser_frame_feeder #(.TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .RST(RST), .src(src),
    .core_rst(core_rst), .core_x(core_x), .core_y(core_y),
    .core_done(core_done),
    .core_c1x(core_c1x), .core_c1y(core_c1y),
    .core_c2x(core_c2x), .core_c2y(core_c2y),
    .res_valid(res_valid),
    .res_c1x(res_c1x), .res_c1y(res_c1y),
    .res_c2x(res_c2x), .res_c2y(res_c2y),
    .res_err(res_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  pt_s  exp_pts[$];
  int   frame_rdy[$];
  res_s exp_res[$];
  int   checks = 0;
  int   errors = 0;
  int   nacc = 0;
  int   last_acc = 0;
  int   last_free = 0;
  int   mon_k = -1;
  int   pulses = 0;
  int   last_x = 0;
  int   last_y = 0;
  int   done_at = -1;
  bit   fix_delay = 0;
  bit   fix_vals = 0;
  bit   no_done = 0;
  bit   prev_res = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Monitor and core model
  always @(negedge CLK) begin
    res_s r;
    pt_s  p;
    int   f;
    bit   busy;
    busy = 0;
    core_done = 1'b0;
    if (RST) begin
      mon_k = -1;
      done_at = -1;
      prev_res = 0;
      last_x = 0;
      last_y = 0;
    end else begin
      if (res_valid) begin
        if (prev_res) chk("res_one_cycle", 1, 0);
        if (exp_res.size() == 0) chk("res_unexpected", 1, 0);
        else begin
          r = exp_res.pop_front();
          chk("res_cyc", cyc, r.cyc);
          chk("res_c1x", int'(res_c1x), r.c1x);
          chk("res_c1y", int'(res_c1y), r.c1y);
          chk("res_c2x", int'(res_c2x), r.c2x);
          chk("res_c2y", int'(res_c2y), r.c2y);
          chk("res_err", int'(res_err), r.err);
        end
      end
      prev_res = res_valid;
      if (core_rst) begin
        busy = 1;
        pulses++;
        if (mon_k >= 0) chk("stream_gap", mon_k, N_OBJ);
        chk("hold_x", int'(core_x), last_x);
        chk("hold_y", int'(core_y), last_y);
        if (frame_rdy.size() == 0) chk("pulse_unexpected", 1, 0);
        else begin
          f = frame_rdy.pop_front();
          chk("pulse_cyc", cyc, ((f > last_free) ? f : last_free) + 2);
        end
        mon_k = 0;
      end else if (mon_k >= 0) begin
        busy = 1;
        if (exp_pts.size() == 0) chk("pt_unexpected", 1, 0);
        else begin
          p = exp_pts.pop_front();
          chk("pt_x", int'(core_x), p.x);
          chk("pt_y", int'(core_y), p.y);
        end
        last_x = int'(core_x);
        last_y = int'(core_y);
        mon_k++;
        if (mon_k == N_OBJ) begin
          mon_k = -1;
          if (no_done) begin
            exp_res.push_back('{c1x: 0, c1y: 0, c2x: 0, c2y: 0,
                                err: 1, cyc: cyc + TO + 1});
            last_free = cyc + TO;
          end else begin
            done_at = cyc + (fix_delay ? 200 : int'($urandom_range(1, 25)));
            fix_delay = 0;
          end
        end
      end
      if (done_at == cyc) begin
        core_done = 1'b1;
        if (fix_vals) begin
          core_c1x = 4'd3; core_c1y = 4'd4;
          core_c2x = 4'd12; core_c2y = 4'd9;
          fix_vals = 0;
        end else begin
          core_c1x = COORD_W'($urandom); core_c1y = COORD_W'($urandom);
          core_c2x = COORD_W'($urandom); core_c2y = COORD_W'($urandom);
        end
        exp_res.push_back('{c1x: int'(core_c1x), c1y: int'(core_c1y),
                            c2x: int'(core_c2x), c2y: int'(core_c2y),
                            err: 0, cyc: cyc + 1});
        last_free = cyc;
        done_at = -1;
      end else if (busy && $urandom_range(0, 5) == 0) begin
        core_done = 1'b1;
        core_c1x = COORD_W'($urandom);
        core_c2y = COORD_W'($urandom);
      end
    end
  end

  task automatic send(input int x, input int y, input int pv);
    int g;
    g = 0;
    while (g < 3000) begin
      @(negedge CLK);
      src.in_x = COORD_W'(x);
      src.in_y = COORD_W'(y);
      src.in_valid = (int'($urandom_range(0, 99)) < pv);
      #1;
      if (src.in_valid && src.in_ready) begin
        exp_pts.push_back('{x: x, y: y});
        last_acc = cyc;
        nacc++;
        if (nacc == N_OBJ) begin
          nacc = 0;
          frame_rdy.push_back(cyc);
        end
        return;
      end
      g++;
    end
    chk("send_timeout", g, 0);
  endtask

  task automatic stop_src();
    @(negedge CLK);
    src.in_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input int pv);
    for (int i = 0; i < n; i++)
      send(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), pv);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (g < 5000 && !(exp_pts.size() == 0 && exp_res.size() == 0 &&
           frame_rdy.size() == 0 && done_at < 0 && mon_k < 0)) begin
      @(negedge CLK);
      #3;
      g++;
    end
    chk("drain_timeout", int'(g < 5000), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_first, a_rdy, p0, g;
    src.in_valid = 1'b0;
    src.in_x = '0;
    src.in_y = '0;
    core_done = 1'b0;
    core_c1x = '0; core_c1y = '0; core_c2x = '0; core_c2y = '0;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_core_rst", int'(core_rst), 1);
    chk("rst_in_ready", int'(src.in_ready), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_err", int'(res_err), 0);
    @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("post_rst_core_rst", int'(core_rst), 0);
    chk("post_rst_in_ready", int'(src.in_ready), 1);
    chk("post_rst_core_x", int'(core_x), 0);
    chk("post_rst_core_y", int'(core_y), 0);
    chk("post_rst_res_c1x", int'(res_c1x), 0);
    chk("post_rst_res_c2y", int'(res_c2y), 0);

    // Frame A (ramp), frame B, then C[0] which must wait for A's bank
    fix_delay = 1;
    fix_vals = 1;
    a_first = -1;
    for (int i = 0; i < N_OBJ; i++) begin
      send(i % 16, i / 16, 100);
      if (i == 0) a_first = last_acc;
    end
    a_rdy = last_acc;
    chk("a_ready_run", a_rdy - a_first, N_OBJ - 1);
    send_frame(N_OBJ, 100);
    chk("b_back_to_back", last_acc, a_rdy + N_OBJ);
    send_frame(1, 100);
    chk("c0_after_release", last_acc, a_rdy + 2 + N_OBJ + 1);
    send_frame(N_OBJ - 1, 50);
    for (int f = 0; f < 3; f++) send_frame(N_OBJ, 50);
    stop_src();
    drain();

    // Reset during STREAM point 20
    send_frame(N_OBJ, 100);
    stop_src();
    g = 0;
    while (mon_k != 21 && g < 500) begin
      @(negedge CLK);
      #3;
      g++;
    end
    chk("reach_point20", mon_k, 21);
    RST = 1'b1;
    #1;
    chk("mid_rst_core_rst", int'(core_rst), 1);
    chk("mid_rst_in_ready", int'(src.in_ready), 0);
    exp_pts.delete();
    frame_rdy.delete();
    exp_res.delete();
    nacc = 0;
    p0 = pulses;
    repeat (2) @(negedge CLK);
    #2 RST = 1'b0;
    last_free = cyc;
    send_frame(N_OBJ / 2, 100);
    stop_src();
    repeat (60) @(negedge CLK);
    #3;
    chk("no_restart_partial", pulses, p0);
    send_frame(N_OBJ - N_OBJ / 2, 70);
    stop_src();
    drain();
    chk("restart_full_frame", pulses, p0 + 1);

`ifdef LASER_FEED_TIMEOUT_EN
    no_done = 1;
    send_frame(N_OBJ, 100);
    stop_src();
    drain();
    no_done = 0;
    send_frame(N_OBJ, 60);
    stop_src();
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
